// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter/sequencer for Dualport_SRAM: one command cycle per access, read data after RD_LAT.
// Round-robin by default; define SRAM_ARB_FIXED_PRI_EN for fixed priority (A wins ties).
module sram_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic          mem_cs,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t     state;
  logic       last_grant;  // 0 = A, 1 = B
  logic       owner;
  logic       op_we;
  logic [1:0] cnt;
  logic       pick_b;

`ifdef SRAM_ARB_FIXED_PRI_EN
  assign pick_b = req_b && !req_a;
`else
  // On a tie the requester that was not granted last time wins.
  assign pick_b = req_b && (!req_a || !last_grant);
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_we      <= 1'b0;
      cnt        <= 2'd0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            owner      <= pick_b;
            last_grant <= pick_b;
            op_we      <= pick_b ? we_b : we_a;
            mem_addr   <= pick_b ? addr_b : addr_a;
            mem_din    <= pick_b ? wdata_b : wdata_a;
            mem_cs     <= 1'b1;
            mem_we     <= pick_b ? we_b : we_a;
            mem_re     <= pick_b ? !we_b : !we_a;
            state      <= CMD;
          end
        end
        CMD: begin
          if (op_we) begin
            ack_a <= !owner;
            ack_b <= owner;
            state <= RESP;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (owner) rdata_b <= mem_dout;
            else       rdata_a <= mem_dout;
            ack_a <= !owner;
            ack_b <= owner;
            state <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
